// File: rtl/com_pixel_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : com_pixel_streamer_if
// Purpose  : Pixel-in / coordinate-out bus between raster source, streamer
//            and centroid accumulator.
// Revision : 1.0 - initial release
// ============================================================================
interface com_pixel_streamer_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        pixel_valid_in;
    logic        mask_in;
    logic        result_valid_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;

    modport streamer (
        input  hcount_in, vcount_in, pixel_valid_in, mask_in, result_valid_in,
        output x_out, y_out, valid_out, tabulate_out
    );

    modport source (
        output hcount_in, vcount_in, pixel_valid_in, mask_in, result_valid_in,
        input  x_out, y_out, valid_out, tabulate_out
    );
endinterface
`default_nettype wire

// File: rtl/com_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : com_pixel_streamer
// Purpose  : Streams masked in-ROI pixel coordinates to the centroid
//            accumulator, one tabulate per frame, holding off while busy.
// Revision : 1.0 - initial release
// ============================================================================
module com_pixel_streamer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int CNT_W    = 20
) (
    input  wire logic                 clk_in,
    input  wire logic                 rst_n_in,
    com_pixel_streamer_if.streamer    pix,
    input  wire logic [10:0]          roi_x0_in,
    input  wire logic [10:0]          roi_x1_in,
    input  wire logic [9:0]           roi_y0_in,
    input  wire logic [9:0]           roi_y1_in,
    output logic                      busy_out,
    output logic [CNT_W-1:0]          frame_count_out,
    output logic                      empty_frame_out,
    output logic [7:0]                skipped_frames_out
);

    localparam logic [1:0]  c_st_armed = 2'd0;
    localparam logic [1:0]  c_st_scan  = 2'd1;
    localparam logic [1:0]  c_st_tab   = 2'd2;
    localparam logic [1:0]  c_st_wait  = 2'd3;
    localparam logic [10:0] c_h_size   = 11'(H_ACTIVE);
    localparam logic [9:0]  c_v_size   = 10'(V_ACTIVE);
    localparam logic [10:0] c_h_last   = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  c_v_last   = 10'(V_ACTIVE - 1);

    logic [1:0]       state_q, state_d;
    logic [10:0]      x_q, x_d, roi_x0_q, roi_x0_d, roi_x1_q, roi_x1_d;
    logic [9:0]       y_q, y_d, roi_y0_q, roi_y0_d, roi_y1_q, roi_y1_d;
    logic             valid_q, valid_d, tab_q, tab_d, empty_q, empty_d;
    logic [CNT_W-1:0] count_q, count_d, fc_q, fc_d;
    logic [7:0]       skip_q, skip_d;

    logic             w_frame_start, w_frame_end, w_in_range, w_hit, w_skip_evt;
    logic [10:0]      w_x0, w_x1;
    logic [9:0]       w_y0, w_y1;
    logic [CNT_W-1:0] w_count_next;

    // The frame-start pixel in ARMED is judged against the ROI being latched now.
    assign w_x0 = (state_q == c_st_armed) ? roi_x0_in : roi_x0_q;
    assign w_x1 = (state_q == c_st_armed) ? roi_x1_in : roi_x1_q;
    assign w_y0 = (state_q == c_st_armed) ? roi_y0_in : roi_y0_q;
    assign w_y1 = (state_q == c_st_armed) ? roi_y1_in : roi_y1_q;

    assign w_frame_start = pix.pixel_valid_in && (pix.hcount_in == 11'd0) && (pix.vcount_in == 10'd0);
    assign w_frame_end   = pix.pixel_valid_in && (pix.hcount_in == c_h_last) && (pix.vcount_in == c_v_last);
    assign w_in_range    = (pix.hcount_in < c_h_size) && (pix.vcount_in < c_v_size);
    assign w_hit         = pix.pixel_valid_in && pix.mask_in && w_in_range
                           && (pix.hcount_in >= w_x0) && (pix.hcount_in <= w_x1)
                           && (pix.vcount_in >= w_y0) && (pix.vcount_in <= w_y1);
    assign w_count_next  = count_q + {{(CNT_W-1){1'b0}}, w_hit};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= c_st_armed;
            x_q      <= '0;
            y_q      <= '0;
            valid_q  <= 1'b0;
            tab_q    <= 1'b0;
            empty_q  <= 1'b0;
            count_q  <= '0;
            fc_q     <= '0;
            skip_q   <= '0;
            roi_x0_q <= '0;
            roi_x1_q <= c_h_last;
            roi_y0_q <= '0;
            roi_y1_q <= c_v_last;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            valid_q  <= valid_d;
            tab_q    <= tab_d;
            empty_q  <= empty_d;
            count_q  <= count_d;
            fc_q     <= fc_d;
            skip_q   <= skip_d;
            roi_x0_q <= roi_x0_d;
            roi_x1_q <= roi_x1_d;
            roi_y0_q <= roi_y0_d;
            roi_y1_q <= roi_y1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_armed: if (w_frame_start) state_d = c_st_scan;
            c_st_scan: begin
                if (w_frame_start)
                    state_d = (count_q != '0) ? c_st_tab : c_st_armed;
                else if (w_frame_end)
                    state_d = (w_count_next != '0) ? c_st_tab : c_st_armed;
            end
            c_st_tab:  state_d = c_st_wait;
            default:   if (pix.result_valid_in) state_d = c_st_armed;
        endcase
    end

    always_comb begin
        valid_d    = 1'b0;
        x_d        = x_q;
        y_d        = y_q;
        tab_d      = (state_q == c_st_tab);
        empty_d    = 1'b0;
        count_d    = count_q;
        fc_d       = fc_q;
        w_skip_evt = 1'b0;
        roi_x0_d   = roi_x0_q;
        roi_x1_d   = roi_x1_q;
        roi_y0_d   = roi_y0_q;
        roi_y1_d   = roi_y1_q;
        case (state_q)
            c_st_armed: begin
                if (w_frame_start) begin
                    roi_x0_d = roi_x0_in;
                    roi_x1_d = roi_x1_in;
                    roi_y0_d = roi_y0_in;
                    roi_y1_d = roi_y1_in;
                    valid_d  = w_hit;
                    count_d  = w_count_next;
                    if (w_hit) begin
                        x_d = pix.hcount_in;
                        y_d = pix.vcount_in;
                    end
                end
            end
            c_st_scan: begin
                if (w_frame_start) begin
                    // Truncated frame: close the old one without the new start pixel.
                    fc_d       = count_q;
                    empty_d    = (count_q == '0);
                    count_d    = '0;
                    w_skip_evt = 1'b1;
                end else begin
                    valid_d = w_hit;
                    count_d = w_count_next;
                    if (w_hit) begin
                        x_d = pix.hcount_in;
                        y_d = pix.vcount_in;
                    end
                    if (w_frame_end) begin
                        fc_d    = w_count_next;
                        empty_d = (w_count_next == '0);
                        count_d = '0;
                    end
                end
            end
            default: w_skip_evt = w_frame_start;
        endcase
        skip_d = (w_skip_evt && (skip_q != 8'hFF)) ? skip_q + 8'd1 : skip_q;
    end

    assign pix.x_out          = x_q;
    assign pix.y_out          = y_q;
    assign pix.valid_out      = valid_q;
    assign pix.tabulate_out   = tab_q;
    assign busy_out           = (state_q == c_st_wait);
    assign frame_count_out    = fc_q;
    assign empty_frame_out    = empty_q;
    assign skipped_frames_out = skip_q;

endmodule
`default_nettype wire

// File: tb/tb_com_pixel_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_com_pixel_streamer
// Purpose  : Directed vector table plus hand sequences for com_pixel_streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_com_pixel_streamer;

    typedef struct {
        logic        pv;
        logic [10:0] h;
        logic [9:0]  v;
        logic        m;
        logic        rv;
        logic        e_valid;
        logic [10:0] e_x;
        logic [9:0]  e_y;
        logic        e_tab;
        logic        e_busy;
        logic        e_empty;
        logic [7:0]  e_skip;
        logic [19:0] e_fc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] roi_x0, roi_x1;
    logic [9:0]  roi_y0, roi_y1;
    logic        busy, empty;
    logic [19:0] fc;
    logic [7:0]  skip;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl [23];

    com_pixel_streamer_if bus ();

    com_pixel_streamer #(.H_ACTIVE(1280), .V_ACTIVE(720), .CNT_W(20)) dut (
        .clk_in             (clk),
        .rst_n_in           (rst_n),
        .pix                (bus),
        .roi_x0_in          (roi_x0),
        .roi_x1_in          (roi_x1),
        .roi_y0_in          (roi_y0),
        .roi_y1_in          (roi_y1),
        .busy_out           (busy),
        .frame_count_out    (fc),
        .empty_frame_out    (empty),
        .skipped_frames_out (skip)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic pv, logic [10:0] h, logic [9:0] v, logic m, logic rv,
                                logic ev, logic [10:0] ex, logic [9:0] ey, logic et,
                                logic eb, logic ee, logic [7:0] es, logic [19:0] ef);
        vec_t r;
        r.pv = pv; r.h = h; r.v = v; r.m = m; r.rv = rv;
        r.e_valid = ev; r.e_x = ex; r.e_y = ey; r.e_tab = et;
        r.e_busy = eb; r.e_empty = ee; r.e_skip = es; r.e_fc = ef;
        return r;
    endfunction

    // Coordinates are only meaningful while valid_out is expected high.
    task automatic expect_out(string name, logic ev, logic [10:0] ex, logic [9:0] ey, logic et,
                              logic eb, logic ee, logic [7:0] es, logic [19:0] ef);
        logic [52:0] act, exp;
        act = {bus.valid_out, ev ? bus.x_out : 11'd0, ev ? bus.y_out : 10'd0,
               bus.tabulate_out, busy, empty, skip, fc};
        exp = {ev, ev ? ex : 11'd0, ev ? ey : 10'd0, et, eb, ee, es, ef};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%b x=%0d y=%0d tab=%b busy=%b empty=%b skip=%0d fc=%0d, expected v=%b x=%0d y=%0d tab=%b busy=%b empty=%b skip=%0d fc=%0d",
                     name, act[52], act[51:41], act[40:31], act[30], act[29], act[28], act[27:20], act[19:0],
                     exp[52], exp[51:41], exp[40:31], exp[30], exp[29], exp[28], exp[27:20], exp[19:0]);
        end
    endtask

    task automatic step(logic pv, logic [10:0] h, logic [9:0] v, logic m, logic rv);
        @(negedge clk);
        bus.pixel_valid_in  = pv;
        bus.hcount_in       = h;
        bus.vcount_in       = v;
        bus.mask_in         = m;
        bus.result_valid_in = rv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 11'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic full_roi();
        roi_x0 = 11'd0; roi_x1 = 11'd1279; roi_y0 = 10'd0; roi_y1 = 10'd719;
    endtask

    initial begin
        // pv  h     v    m  rv   ev  ex    ey   tab busy emp skip fc
        tbl[0]  = mk(1, 0,    0,   0, 0,  0, 0,    0,   0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 10,   20,  1, 0,  1, 10,   20,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 30,   40,  1, 0,  1, 30,   40,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 5,    5,   1, 0,  0, 0,    0,   0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 50,   60,  1, 0,  1, 50,   60,  0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 100,  100, 0, 0,  0, 0,    0,   0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1279, 719, 0, 0,  0, 0,    0,   0, 0, 0, 0, 3);
        tbl[7]  = mk(0, 0,    0,   0, 0,  0, 0,    0,   1, 1, 0, 0, 3);
        tbl[8]  = mk(0, 0,    0,   0, 0,  0, 0,    0,   0, 1, 0, 0, 3);
        tbl[9]  = mk(1, 0,    0,   1, 0,  0, 0,    0,   0, 1, 0, 1, 3);
        tbl[10] = mk(1, 10,   20,  1, 0,  0, 0,    0,   0, 1, 0, 1, 3);
        tbl[11] = mk(1, 1279, 719, 1, 0,  0, 0,    0,   0, 1, 0, 1, 3);
        tbl[12] = mk(0, 0,    0,   0, 1,  0, 0,    0,   0, 0, 0, 1, 3);
        tbl[13] = mk(1, 0,    0,   1, 0,  1, 0,    0,   0, 0, 0, 1, 3);
        tbl[14] = mk(1, 1279, 719, 1, 0,  1, 1279, 719, 0, 0, 0, 1, 2);
        tbl[15] = mk(0, 0,    0,   0, 0,  0, 0,    0,   1, 1, 0, 1, 2);
        tbl[16] = mk(0, 0,    0,   0, 1,  0, 0,    0,   0, 0, 0, 1, 2);
        tbl[17] = mk(0, 0,    0,   0, 1,  0, 0,    0,   0, 0, 0, 1, 2);
        tbl[18] = mk(1, 0,    0,   0, 0,  0, 0,    0,   0, 0, 0, 1, 2);
        tbl[19] = mk(1, 640,  360, 0, 0,  0, 0,    0,   0, 0, 0, 1, 2);
        tbl[20] = mk(1, 1300, 719, 1, 0,  0, 0,    0,   0, 0, 0, 1, 2);
        tbl[21] = mk(1, 1279, 719, 0, 0,  0, 0,    0,   0, 0, 1, 1, 0);
        tbl[22] = mk(0, 0,    0,   0, 0,  0, 0,    0,   0, 0, 0, 1, 0);

        full_roi();
        bus.pixel_valid_in = 1'b0; bus.hcount_in = '0; bus.vcount_in = '0;
        bus.mask_in = 1'b0; bus.result_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset_state", 0, 0, 0, 0, 0, 0, 8'd0, 20'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].pv, tbl[i].h, tbl[i].v, tbl[i].m, tbl[i].rv);
            expect_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_x, tbl[i].e_y,
                       tbl[i].e_tab, tbl[i].e_busy, tbl[i].e_empty, tbl[i].e_skip, tbl[i].e_fc);
        end

        // Truncated frame: 7 masked pixels in the first 500 lines, then a new start.
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            step(1, 11'(k * 3), 10'(k * 70), 1, 0);
            expect_out($sformatf("trunc_px%0d", k), 1, 11'(k * 3), 10'(k * 70), 0, 0, 0, 8'd1, 20'd0);
            step(1, 11'(k * 3 + 1), 10'(k * 70), 0, 0);
        end
        step(1, 0, 0, 1, 0);
        expect_out("trunc_close", 0, 0, 0, 0, 0, 0, 8'd2, 20'd7);
        idle();
        expect_out("trunc_tab", 0, 0, 0, 1, 1, 0, 8'd2, 20'd7);
        step(1, 10, 20, 1, 0);
        expect_out("trunc_skipped_px", 0, 0, 0, 0, 1, 0, 8'd2, 20'd7);
        step(0, 0, 0, 0, 1);
        expect_out("trunc_release", 0, 0, 0, 0, 0, 0, 8'd2, 20'd7);

        // ROI window x 100..101, y 5, latched at frame start.
        roi_x0 = 11'd100; roi_x1 = 11'd101; roi_y0 = 10'd5; roi_y1 = 10'd5;
        step(1, 0, 0, 1, 0);
        expect_out("roi_start", 0, 0, 0, 0, 0, 0, 8'd2, 20'd7);
        full_roi();
        for (int x = 98; x <= 103; x++) begin
            step(1, 11'(x), 10'd5, 1, 0);
            expect_out($sformatf("roi_x%0d", x), (x == 100 || x == 101), 11'(x), 10'd5, 0, 0, 0, 8'd2, 20'd7);
        end
        step(1, 100, 4, 1, 0);
        expect_out("roi_row4", 0, 0, 0, 0, 0, 0, 8'd2, 20'd7);
        step(1, 100, 6, 1, 0);
        expect_out("roi_row6", 0, 0, 0, 0, 0, 0, 8'd2, 20'd7);
        step(1, 1279, 719, 1, 0);
        expect_out("roi_end", 0, 0, 0, 0, 0, 0, 8'd2, 20'd2);
        idle();
        expect_out("roi_tab", 0, 0, 0, 1, 1, 0, 8'd2, 20'd2);
        step(0, 0, 0, 0, 1);

        // Inverted ROI must emit nothing and end as an empty frame.
        roi_x0 = 11'd5; roi_x1 = 11'd4;
        step(1, 0, 0, 1, 0);
        step(1, 5, 5, 1, 0);
        expect_out("empty_roi_px", 0, 0, 0, 0, 0, 0, 8'd2, 20'd2);
        step(1, 1279, 719, 1, 0);
        expect_out("empty_roi_end", 0, 0, 0, 0, 0, 1, 8'd2, 20'd0);
        full_roi();

        // Asynchronous reset mid-scan, then stale pixels before the next start.
        step(1, 0, 0, 0, 0);
        step(1, 10, 10, 1, 0);
        expect_out("pre_reset_px", 1, 10, 10, 0, 0, 0, 8'd2, 20'd0);
        #2 rst_n = 1'b0;
        #1 expect_out("async_reset", 0, 0, 0, 0, 0, 0, 8'd0, 20'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 20, 20, 1, 0);
        expect_out("post_reset_stale", 0, 0, 0, 0, 0, 0, 8'd0, 20'd0);
        step(1, 0, 0, 1, 0);
        expect_out("post_reset_start", 1, 0, 0, 0, 0, 0, 8'd0, 20'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
